// File: rtl/pot_smoother_if.sv
// pot_smoother_if: pot ADC sample bus and smoothed-word output bundle
interface pot_smoother_if #(parameter int N = 10) ();
  logic                pot_valid;
  logic [1:0][N-1:0]   pot_adc;
  logic                filt_type;
  logic [N-1:0]        pot_word;
  logic                word_valid;
  modport master (output pot_valid, pot_adc, filt_type, input pot_word, word_valid);
  modport slave (input pot_valid, pot_adc, filt_type, output pot_word, word_valid);
endinterface

// File: rtl/pot_smoother.sv
// pot_smoother: block-averages pot ADC samples and publishes a word on change (POT_SMOOTHER_HYST_EN enables hysteresis)
module pot_smoother #(
  parameter int N        = 10,
  parameter int AVG_LOG2 = 3,
  parameter int HYST     = 4
) (
  input logic            clk,
  input logic            reset_n,
  pot_smoother_if.slave  bus
);
  typedef enum logic {FILL, EVAL} state_t;
  state_t                state_q;
  logic [2:0]            sync_q;
  logic                  ft_q, force_q, wv_q;
  logic [N-1:0]          word_q, avg_q, avg_d, sample;
  logic [N+AVG_LOG2-1:0] acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0]   cnt_q, cnt_d;
  logic                  rise, change, accept, last, upd;
`ifdef POT_SMOOTHER_HYST_EN
  logic [N:0]            mag;
`endif
  // sample selection, edge detect, restart on channel change, block accumulation
  always_comb begin
    sample = bus.pot_adc[bus.filt_type];
    rise   = sync_q[1] & ~sync_q[2];
    change = bus.filt_type != ft_q;
    accept = rise & ~change;
    last   = accept & (&cnt_q);
    sum    = acc_q + (N+AVG_LOG2)'(sample);
    avg_d  = N'(sum >> AVG_LOG2);
    acc_d  = accept ? (last ? '0 : sum) : acc_q;
    cnt_d  = accept ? cnt_q + 1'b1 : cnt_q;
`ifdef POT_SMOOTHER_HYST_EN
    mag    = (avg_q >= word_q) ? {1'b0, avg_q} - {1'b0, word_q} : {1'b0, word_q} - {1'b0, avg_q};
    upd    = force_q | (mag >= (N+1)'(HYST));
`else
    upd    = 1'b1;
`endif
  end
  // synchroniser, FILL/EVAL controller and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      ft_q    <= 1'b0;
      force_q <= 1'b1;
      wv_q    <= 1'b0;
      word_q  <= '0;
      avg_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      state_q <= FILL;
    end else begin
      sync_q <= {sync_q[1:0], bus.pot_valid};
      ft_q   <= bus.filt_type;
      wv_q   <= 1'b0;
      if (change) begin
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= FILL;
        force_q <= 1'b1;
      end else begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        state_q <= last ? EVAL : FILL;
        if (last) avg_q <= avg_d;
        if (state_q == EVAL && upd) begin
          word_q  <= avg_q;
          wv_q    <= 1'b1;
          force_q <= 1'b0;
        end
      end
    end
  end
  assign bus.pot_word   = word_q;
  assign bus.word_valid = wv_q;
endmodule

// File: tb/tb_pot_smoother.sv
// tb_pot_smoother: directed scoreboard bench for pot_smoother
module tb_pot_smoother;
  localparam int N = 10;
`ifdef POT_SMOOTHER_HYST_EN
  localparam bit HE = 1'b1;
`else
  localparam bit HE = 1'b0;
`endif
  typedef struct {int w; int c;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cur_word = 0;
  exp_t q[$];
  exp_t e;
  pot_smoother_if #(.N(N)) bus ();
  pot_smoother #(.N(N), .AVG_LOG2(3), .HYST(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: every word_valid pulse must match the oldest expected publication
  always @(negedge clk) begin
    if (reset_n && bus.word_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got word=%0d at cyc=%0d, required no pulse", bus.pot_word, cyc);
      end else begin
        e = q.pop_front();
        if (bus.pot_word !== N'(e.w) || cyc != e.c) begin
          errors++;
          $display("FAIL publish: got word=%0d cyc=%0d, required word=%0d cyc=%0d", bus.pot_word, cyc, e.w, e.c);
        end
      end
    end
  end
  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask
  // one pot_valid pulse; pw >= 0 means this sample should publish pw
  task automatic sample(input int v, input int pw);
    @(negedge clk);
    bus.pot_adc[bus.filt_type]  = N'(v);
    bus.pot_adc[~bus.filt_type] = N'(1023 - v);
    bus.pot_valid = 1'b1;
    if (pw >= 0) begin
      q.push_back('{pw, cyc + 4});
      cur_word = pw;
    end
    repeat (3) @(negedge clk);
    bus.pot_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic block(input string name, input int v, input int last_v, input int pw);
    repeat (7) sample(v, -1);
    sample(last_v, pw);
    repeat (4) @(negedge clk);
    check({name, "_word"}, int'(bus.pot_word), cur_word);
    check({name, "_pending"}, q.size(), 0);
  endtask
  task automatic set_ft(input logic f);
    @(negedge clk);
    bus.filt_type = f;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    bus.pot_valid = 1'b0;
    bus.pot_adc   = '0;
    bus.filt_type = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_word", int'(bus.pot_word), 0);
    check("reset_valid", int'(bus.word_valid), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    block("const512", 512, 512, 512);
    block("hyst514", 514, 514, HE ? -1 : 514);
    block("hyst516", 516, 516, 516);
    block("full1023", 1023, 1023, 1023);
    block("zero", 0, 0, 0);
    block("trunc0", 1, 0, HE ? -1 : 0);
    block("trunc1022", 1023, 1016, 1022);
    repeat (5) sample(300, -1);
    set_ft(1'b1);
    check("switch_hold", int'(bus.pot_word), 1022);
    block("ch1_100", 100, 100, 100);
    set_ft(1'b0);
    block("ch0_forced", 101, 101, 101);
    repeat (3) sample(700, -1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_word", int'(bus.pot_word), 0);
    check("midreset_valid", int'(bus.word_valid), 0);
    cur_word = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    block("after_reset700", 700, 700, 700);
    repeat (10) @(negedge clk);
    check("final_pending", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
